reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry general-purpose register file directly upstream of the ALU.
- Two combinational read ports drive the ALU's operand1/operand2 inputs.
- One synchronous write port takes write-back data: ALU result or memory load data, selected outside this block.
- Register 0 is hardwired to zero, matching the processor's ISA convention.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, width of register index ports.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- reg_write  input  1  write enable; 1 = commit write_data to write_addr at next rising clk.
- write_addr  input  ADDR_WIDTH  destination register index.
- write_data  input  DATA_WIDTH  write-back value.
- read_addr1  input  ADDR_WIDTH  source register index, port 1.
- read_addr2  input  ADDR_WIDTH  source register index, port 2.
- read_data1  output  DATA_WIDTH  contents of read_addr1; drives ALU operand1.
- read_data2  output  DATA_WIDTH  contents of read_addr2; drives ALU operand2 path (immediate mux sits outside).

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n=0 immediately clears all NUM_REGS entries to 0, without waiting for clk.
  - read_data1/read_data2 therefore read 0 while reset is held.
  - Writes are ignored while rst_n=0.
  - Deassertion is synchronised outside this block.
  - Reset asserted in the same cycle as a pending write: reset wins, and the entry is 0 after the edge.
- Storage: NUM_REGS x DATA_WIDTH flops. Entry 0 is never written and always reads 0; it may be implemented as a constant.
- Write:
  - On rising clk with rst_n=1 and reg_write=1 and write_addr!=0, entry[write_addr] <= write_data.
  - reg_write=0: no entry changes, whatever write_addr/write_data show.
  - write_addr=0 with reg_write=1: silently discarded, no error flag.
- Read:
  - Purely combinational, zero-cycle latency: read_data1 = entry[read_addr1], read_data2 = entry[read_addr2].
  - A read of index 0 returns 0.
  - Both ports may address the same register simultaneously; both return the same value.
- Read-during-write (same index, same cycle), without the optional feature:
  - Before the edge, the read returns the old value.
  - From the edge onward, it returns the new value.
  - This is the required single-cycle-processor timing: the instruction reads its sources and writes its destination in one cycle (e.g. add x5,x5,x5 reads old x5).
- No X propagation: every entry has a defined reset value; out-of-range indexes cannot occur because NUM_REGS = 2**ADDR_WIDTH.
- Widths: no arithmetic; data passes through unmodified at DATA_WIDTH.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - A write-to-read bypass is compiled in. When rst_n=1, reg_write=1, write_addr!=0 and read_addrN==write_addr, read_dataN = write_data combinationally in the same cycle.
  - Used when the core is later pipelined and write-back and decode share a cycle.
  - Bypass never applies to index 0.
- Not defined: no bypass logic; read-during-write behaves as in Behaviour (old value until the edge).

Test Plan:
- Write x5=0xDEADBEEF, reg_write=1, clock once; set read_addr1=5 -> read_data1=0xDEADBEEF in the same cycle as the address change.
- Write x0=0xFFFFFFFF with reg_write=1, clock -> read_data1 and read_data2 at address 0 both =0x00000000.
- x7=0x00000011; present write_addr=7, write_data=0x0000AAAA, reg_write=0, clock -> read x7 =0x00000011.
- x9=0x1; in one cycle, read_addr1=read_addr2=9, write_addr=9, write_data=0x2, reg_write=1:
  - Without REG_FILE_BYPASS_EN: both reads =0x1 before the edge, 0x2 after.
  - With REG_FILE_BYPASS_EN: both =0x2 before the edge.
- Write x3=0x12345678 and x31=0x87654321, then drop rst_n mid-cycle, between clock edges -> read_data1(x3) and read_data2(x31) become 0 with no clk edge. Release rst_n and clock a write x3=0x5 -> x3=0x5, x31=0.
- Walk all 31 writable registers with pattern 0xA5A50000+index, then read each on both ports -> every value matches; x0 =0.

Source files
------------

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write port, x0 reads 0.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    // Entry 0 has no storage; its reads fall through to the zero default below.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic                  write_en;

    assign write_en = reg_write && (write_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (write_addr == ADDR_WIDTH'(i)) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (read_addr1 == ADDR_WIDTH'(i)) begin
                read_data1 = regs[i];
            end
            if (read_addr2 == ADDR_WIDTH'(i)) begin
                read_data2 = regs[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        // write_en already excludes index 0, so x0 is never forwarded.
        if (rst_n && write_en) begin
            if (read_addr1 == write_addr) begin
                read_data1 = write_data;
            end
            if (read_addr2 == write_addr) begin
                read_data2 = write_data;
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed test-plan steps followed by randomized traffic
// checked against an array-based register model.
module tb_reg_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reg_write;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_addr1;
    logic [AW-1:0] read_addr2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] model [0:NR-1];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_write (reg_write),
        .write_addr(write_addr),
        .write_data(write_data),
        .read_addr1(read_addr1),
        .read_addr2(read_addr2),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic void clear_model();
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
    endfunction

    // Architectural view of a read port given current inputs.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr);
        if (!rst_n) return '0;
        if (addr == 0) return '0;
        if (BYPASS && reg_write && write_addr != 0 && addr == write_addr) return write_data;
        return model[addr];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, ".rd1"}, read_data1, exp_read(read_addr1));
        check({tag, ".rd2"}, read_data2, exp_read(read_addr2));
    endtask

    // Advance through the next rising edge, committing to the model what the DUT should commit.
    task automatic tick();
        @(posedge clk);
        if (rst_n && reg_write && write_addr != 0) model[write_addr] = write_data;
        #1;
    endtask

    task automatic set_reset(input logic v);
        rst_n = v;
        if (!v) clear_model();
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    initial begin
        reg_write  = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr1 = '0;
        read_addr2 = '0;
        set_reset(1'b0);

        // Reset state, and a write attempted while reset is held is ignored.
        for (int i = 1; i < int'(NR); i += 10) begin
            read_addr1 = AW'(i);
            read_addr2 = AW'(NR - 1 - i);
            check_ports("reset_state");
        end
        reg_write  = 1'b1;
        write_addr = 5'd4;
        write_data = 32'hCAFEF00D;
        tick();
        reg_write  = 1'b0;
        read_addr1 = 5'd4;
        #1 check("write_in_reset", read_data1, 32'h0);

        @(negedge clk);
        set_reset(1'b1);

        // x5 write then read with zero-cycle latency after address change.
        write_reg(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        read_addr1 = 5'd5;
        #1 check("x5_read", read_data1, 32'hDEADBEEF);

        // x0 write discarded.
        write_reg(5'd0, 32'hFFFFFFFF);
        read_addr1 = 5'd0;
        read_addr2 = 5'd0;
        #1;
        check("x0_rd1", read_data1, 32'h0);
        check("x0_rd2", read_data2, 32'h0);

        // reg_write=0 leaves entry untouched.
        write_reg(5'd7, 32'h00000011);
        @(negedge clk);
        reg_write  = 1'b0;
        write_addr = 5'd7;
        write_data = 32'h0000AAAA;
        tick();
        read_addr1 = 5'd7;
        #1 check("x7_no_we", read_data1, 32'h00000011);

        // Read-during-write on both ports.
        write_reg(5'd9, 32'h1);
        @(negedge clk);
        read_addr1 = 5'd9;
        read_addr2 = 5'd9;
        write_addr = 5'd9;
        write_data = 32'h2;
        reg_write  = 1'b1;
        #1;
        check("rdw_pre_rd1", read_data1, BYPASS ? 32'h2 : 32'h1);
        check("rdw_pre_rd2", read_data2, BYPASS ? 32'h2 : 32'h1);
        tick();
        check("rdw_post_rd1", read_data1, 32'h2);
        check("rdw_post_rd2", read_data2, 32'h2);
        reg_write = 1'b0;

        // Asynchronous reset mid-cycle, with a write pending across the next edge.
        write_reg(5'd3, 32'h12345678);
        write_reg(5'd31, 32'h87654321);
        read_addr1 = 5'd3;
        read_addr2 = 5'd31;
        #1;
        check("pre_rst_x3", read_data1, 32'h12345678);
        check("pre_rst_x31", read_data2, 32'h87654321);
        #1;
        set_reset(1'b0);
        #1;
        check("async_rst_x3", read_data1, 32'h0);
        check("async_rst_x31", read_data2, 32'h0);
        reg_write  = 1'b1;
        write_addr = 5'd12;
        write_data = 32'h0BADBEEF;
        tick();
        reg_write  = 1'b0;
        read_addr1 = 5'd12;
        #1 check("rst_beats_write", read_data1, 32'h0);
        @(negedge clk);
        set_reset(1'b1);
        write_reg(5'd3, 32'h5);
        read_addr1 = 5'd3;
        read_addr2 = 5'd31;
        #1;
        check("post_rst_x3", read_data1, 32'h5);
        check("post_rst_x31", read_data2, 32'h0);

        // Walk every writable register.
        for (int i = 1; i < int'(NR); i++) write_reg(AW'(i), 32'hA5A50000 + i);
        for (int i = 0; i < int'(NR); i++) begin
            @(negedge clk);
            read_addr1 = AW'(i);
            read_addr2 = AW'(i);
            #1;
            check("walk_rd1", read_data1, (i == 0) ? 32'h0 : 32'hA5A50000 + i);
            check("walk_rd2", read_data2, (i == 0) ? 32'h0 : 32'hA5A50000 + i);
        end

        // Randomized traffic, including occasional asynchronous reset pulses.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            set_reset(($urandom_range(0, 49) != 0));
            reg_write  = ($urandom_range(0, 3) != 0);
            write_addr = AW'($urandom_range(0, NR - 1));
            write_data = $urandom;
            read_addr1 = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom_range(0, NR - 1));
            read_addr2 = ($urandom_range(0, 3) == 0) ? read_addr1 : AW'($urandom_range(0, NR - 1));
            check_ports("rand_pre");
            tick();
            check_ports("rand_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
